mfp_ahb_uart_slave: RTL and testbench



---
 rtl/mfp_ahb_uart_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mfp_ahb_uart_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_uart_slave.sv
// AHB-Lite UART slave: 8N1 transmitter with TX FIFO, single-entry RX holding register.
// Optional internal loopback (CTRL[0]) is compiled in with `define MFP_UART_LOOPBACK_EN.
module mfp_ahb_uart_slave #(
  parameter int unsigned TX_FIFO_LOG2     = 3,
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        SI_Endian,
  input  logic        UART_RX,
  output logic        UART_TX
);

  localparam int unsigned Depth = 2 ** TX_FIFO_LOG2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT, HSIZE, SI_Endian, HADDR[31:4], HADDR[1:0],
                           HWDATA[31:16], HTRANS[0]};

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // Bus address phase capture
  logic       accept;
  logic [1:0] addr_q;
  logic       write_q, valid_q;

  assign accept = HSEL & HTRANS[1] & HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        addr_q  <= HADDR[3:2];
        write_q <= HWRITE;
      end
    end
  end

  logic wr_data, wr_stat, wr_baud, wr_ctrl, rd_data, rd_en;
  assign rd_en   = valid_q & ~write_q;
  assign wr_data = valid_q & write_q & (addr_q == 2'd0);
  assign wr_stat = valid_q & write_q & (addr_q == 2'd1);
  assign wr_baud = valid_q & write_q & (addr_q == 2'd2);
  assign wr_ctrl = valid_q & write_q & (addr_q == 2'd3);
  assign rd_data = rd_en & (addr_q == 2'd0);

  // TX FIFO
  logic [7:0]            fifo_mem [Depth];
  logic [TX_FIFO_LOG2:0] wptr_q, rptr_q;
  logic                  fifo_empty, fifo_full, push, tx_pop;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[TX_FIFO_LOG2] != rptr_q[TX_FIFO_LOG2]) &&
                      (wptr_q[TX_FIFO_LOG2-1:0] == rptr_q[TX_FIFO_LOG2-1:0]);
  assign push       = wr_data & ~fifo_full;

  always_ff @(posedge HCLK) begin
    if (push) fifo_mem[wptr_q[TX_FIFO_LOG2-1:0]] <= HWDATA[7:0];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push)   wptr_q <= wptr_q + 1'b1;
      if (tx_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  logic [15:0] baud_q;
  logic        ctrl_q;

  // TX FSM
  uart_st_e    tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tx_st_q  <= StIdle;
      tx_cnt_q <= 16'd0;
      tx_bit_q <= 3'd0;
      tx_sh_q  <= 8'd0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      StIdle: begin
        if (!fifo_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = fifo_mem[rptr_q[TX_FIFO_LOG2-1:0]];
          tx_cnt_d = baud_q;
          tx_st_d  = StStart;
        end
      end
      StStart: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = baud_q;
          tx_bit_d = 3'd0;
          tx_st_d  = StData;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      StData: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = baud_q;
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          if (tx_bit_q == 3'd7) tx_st_d = StStop;
          else tx_bit_d = tx_bit_q + 1'b1;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      StStop: begin
        if (tx_cnt_q == 16'd0) begin
          // Chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = fifo_mem[rptr_q[TX_FIFO_LOG2-1:0]];
            tx_cnt_d = baud_q;
            tx_st_d  = StStart;
          end else tx_st_d = StIdle;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      default: tx_st_d = StIdle;
    endcase
  end

  always_comb begin
    UART_TX = 1'b1;
    unique case (tx_st_q)
      StStart: UART_TX = 1'b0;
      StData:  UART_TX = tx_sh_q[0];
      default: UART_TX = 1'b1;
    endcase
  end

  // RX path
  logic       rx_src, rx_s, rx_prev_q;
  logic [1:0] rx_sync_q;

`ifdef MFP_UART_LOOPBACK_EN
  assign rx_src = ctrl_q ? UART_TX : UART_RX;
`else
  assign rx_src = UART_RX;
`endif

  assign rx_s = rx_sync_q[1];

  uart_st_e    rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_done, rx_ferr;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_st_q   <= StIdle;
      rx_cnt_q  <= 16'd0;
      rx_bit_q  <= 3'd0;
      rx_sh_q   <= 8'd0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_src};
      rx_prev_q <= rx_s;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    unique case (rx_st_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) begin
          rx_cnt_d = {1'b0, baud_q[15:1]};
          rx_st_d  = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s) rx_st_d = StIdle;
          else begin
            rx_cnt_d = baud_q;
            rx_bit_d = 3'd0;
            rx_st_d  = StData;
          end
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      StData: begin
        if (rx_cnt_q == 16'd0) begin
          rx_cnt_d = baud_q;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = StStop;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      StStop: begin
        if (rx_cnt_q == 16'd0) rx_st_d = StIdle;
        else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      default: rx_st_d = StIdle;
    endcase
  end

  assign rx_done = (rx_st_q == StStop) && (rx_cnt_q == 16'd0) && rx_s;
  assign rx_ferr = (rx_st_q == StStop) && (rx_cnt_q == 16'd0) && !rx_s;

  // Control and status registers
  logic [7:0] rx_byte_q;
  logic       rx_valid_q, rx_ovr_q, frame_err_q, tx_empty;

  assign tx_empty = fifo_empty & (tx_st_q == StIdle);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      baud_q      <= DEFAULT_BAUD_DIV;
      ctrl_q      <= 1'b0;
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (wr_baud) baud_q <= HWDATA[15:0];
      if (wr_ctrl) ctrl_q <= HWDATA[0];
      // A byte landing in the same cycle as a DATA read wins over the read's clear
      if (rx_done) begin
        rx_byte_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end else if (rd_data) rx_valid_q <= 1'b0;
      if (rx_done && rx_valid_q && !rd_data) rx_ovr_q <= 1'b1;
      else if (wr_stat) rx_ovr_q <= 1'b0;
      if (rx_ferr) frame_err_q <= 1'b1;
      else if (wr_stat) frame_err_q <= 1'b0;
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_en) begin
      unique case (addr_q)
        2'd0: HRDATA = {23'd0, rx_valid_q, rx_byte_q};
        2'd1: HRDATA = {27'd0, frame_err_q, rx_ovr_q, rx_valid_q, tx_empty, fifo_full};
        2'd2: HRDATA = {16'd0, baud_q};
        2'd3: HRDATA = {31'd0, ctrl_q};
        default: HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_ahb_uart_slave.sv
// Self-checking bench for mfp_ahb_uart_slave: random TX/RX bytes against a frame-level model.
module tb_mfp_ahb_uart_slave;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] HADDR = '0;
  logic [2:0]  HBURST = '0;
  logic        HMASTLOCK = 1'b0;
  logic [3:0]  HPROT = '0;
  logic        HSEL = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [1:0]  HTRANS = '0;
  logic [31:0] HWDATA = '0;
  logic        HWRITE = 1'b0;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;
  logic        SI_Endian = 1'b0;
  logic        UART_RX = 1'b1;
  logic        UART_TX;

  mfp_ahb_uart_slave dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
    .HPROT(HPROT), .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .SI_Endian(SI_Endian), .UART_RX(UART_RX), .UART_TX(UART_TX)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle record of the TX line
  bit rec = 1'b0;
  bit trace[$];
  initial forever begin
    @(posedge HCLK);
    #2;
    if (rec) trace.push_back(UART_TX);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Receiver model
  bit       m_valid, m_ovr, m_ferr;
  bit [7:0] m_byte;

  function automatic logic [31:0] exp_status();
    return {27'd0, m_ferr, m_ovr, m_valid, 1'b1, 1'b0};
  endfunction

  task automatic model_rx(input bit [7:0] b, input bit stop);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_byte  = b;
    end else m_ferr = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick(1);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    tick(1);
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] d;
    ahb_read(32'h0, d);
    check_val(tag, d, {23'd0, m_valid, m_byte});
    m_valid = 1'b0;
  endtask

  task automatic status_check(input string tag);
    logic [31:0] d;
    ahb_read(32'h4, d);
    check_val(tag, d, exp_status());
  endtask

  task automatic wait_tx_idle(input int budget);
    logic [31:0] d;
    int n = 0;
    d = '0;
    while (n < budget && !d[1]) begin
      ahb_read(32'h4, d);
      n++;
    end
    check_val("tx_idle_reached", d[1], 1'b1);
  endtask

  // Four cycles per bit (BAUD=3)
  task automatic uart_send(input bit [7:0] b, input bit stop);
    bit [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      UART_RX = bits[k];
      tick(4);
    end
    UART_RX = 1'b1;
    tick(10);
    model_rx(b, stop);
  endtask

  function automatic logic [39:0] exp_frame(input bit [7:0] b);
    bit [9:0] bits;
    logic [39:0] f;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) f[i] = bits[i / 4];
    return f;
  endfunction

  function automatic int find_start();
    for (int i = 0; i < trace.size(); i++) if (trace[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic check_frames(input string tag, input bit [7:0] bytes[$]);
    int s;
    logic [39:0] f;
    int zeros;
    s = find_start();
    check_val({tag, "_start_found"}, (s >= 0 && trace.size() >= s + 40 * bytes.size()), 1'b1);
    if (s >= 0 && trace.size() >= s + 40 * bytes.size()) begin
      for (int j = 0; j < bytes.size(); j++) begin
        for (int i = 0; i < 40; i++) f[i] = trace[s + 40 * j + i];
        check_val($sformatf("%s_frame%0d", tag, j), f, exp_frame(bytes[j]));
      end
      zeros = 0;
      for (int i = s + 40 * bytes.size(); i < trace.size(); i++) if (!trace[i]) zeros++;
      check_val({tag, "_no_extra_frame"}, zeros, 0);
    end
  endtask

  initial begin
    logic [31:0] d;
    bit [7:0] q[$];
    bit [7:0] b;
    bit       st;
    int       zeros;

    m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = 0;
    tick(3);
    HRESET = 1'b0;
    tick(1);

    check_val("reset_tx_line", UART_TX, 1'b1);
    check_val("reset_hready_hresp", {HREADY, HRESP}, 2'b10);
    check_val("reset_hrdata", HRDATA, 32'h0);
    ahb_read(32'h4, d); check_val("reset_status", d, 32'h2);
    ahb_read(32'h8, d); check_val("reset_baud", d, 32'd433);
    ahb_read(32'hC, d); check_val("reset_ctrl", d, 32'h0);
    read_data_check("reset_data");

    // IDLE transfer and deselected NONSEQ must not write
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h8; tick(1);
    HSEL = 1'b0; HTRANS = 2'b10; HWDATA = 32'h7; tick(1);
    HTRANS = 2'b00; HWRITE = 1'b0; tick(1);
    ahb_read(32'h8, d); check_val("idle_transfer_ignored", d, 32'd433);

    ahb_write(32'h8, 32'hABCD_0003);
    ahb_read(32'h8, d); check_val("baud_upper_zero", d, 32'd3);

    // Single frame 0xA5
    trace.delete(); rec = 1'b1;
    ahb_write(32'h0, 32'h0000_00A5);
    wait_tx_idle(100);
    tick(4); rec = 1'b0;
    q.delete(); q.push_back(8'hA5);
    check_frames("tx_a5", q);
    ahb_read(32'h4, d); check_val("status_after_a5", d, 32'h2);

    // Nine random back-to-back bytes fill shifter + FIFO; tenth is dropped
    q.delete();
    trace.delete(); rec = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      ahb_write(32'h0, {24'd0, b});
    end
    ahb_read(32'h4, d); check_val("fifo_full_after_9", d, 32'h1);
    ahb_write(32'h0, 32'h0000_00FF);
    ahb_read(32'h4, d); check_val("fifo_full_after_drop", d, 32'h1);
    wait_tx_idle(400);
    tick(20); rec = 1'b0;
    check_frames("tx_burst", q);

    // Two frames without a read: overrun, latest byte kept
    uart_send(8'($urandom), 1'b1);
    uart_send(8'($urandom), 1'b1);
    status_check("rx_overrun_status");
    read_data_check("rx_overrun_data");
    read_data_check("rx_data_after_pop");
    ahb_write(32'h4, 32'h0); m_ovr = 0; m_ferr = 0;
    status_check("rx_overrun_cleared");

    // Bad stop bit
    uart_send(8'($urandom), 1'b0);
    status_check("rx_frame_err_status");
    ahb_write(32'h4, 32'h0); m_ovr = 0; m_ferr = 0;
    status_check("rx_frame_err_cleared");

    // One-cycle glitch is a false start
    UART_RX = 1'b0; tick(1); UART_RX = 1'b1; tick(50);
    status_check("rx_false_start");

    // Random receive traffic
    for (int it = 0; it < 8; it++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      uart_send(b, st);
      if ($urandom_range(0, 1) == 1) read_data_check($sformatf("rx_rand_data%0d", it));
      status_check($sformatf("rx_rand_status%0d", it));
      if ($urandom_range(0, 2) == 0) begin
        ahb_write(32'h4, 32'h0); m_ovr = 0; m_ferr = 0;
      end
    end
    ahb_write(32'h4, 32'h0); m_ovr = 0; m_ferr = 0;
    read_data_check("rx_drain");

    // CTRL readback and loopback behaviour
    ahb_write(32'hC, 32'hFFFF_FFFF);
    ahb_read(32'hC, d); check_val("ctrl_readback", d, 32'h1);
    ahb_write(32'h0, 32'h0000_005A);
    wait_tx_idle(100);
    tick(12);
`ifdef MFP_UART_LOOPBACK_EN
    model_rx(8'h5A, 1'b1);
`endif
    read_data_check("loopback_data");
    ahb_write(32'hC, 32'h0);

    // Reset mid-frame with a byte still queued
    ahb_write(32'h0, {24'd0, 8'($urandom)});
    ahb_write(32'h0, {24'd0, 8'($urandom)});
    tick(15);
    HRESET = 1'b1;
    tick(1);
    check_val("midframe_reset_tx", UART_TX, 1'b1);
    HRESET = 1'b0;
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = 0;
    trace.delete(); rec = 1'b1;
    ahb_read(32'h4, d); check_val("midframe_reset_status", d, 32'h2);
    ahb_read(32'h8, d); check_val("midframe_reset_baud", d, 32'd433);
    tick(100); rec = 1'b0;
    zeros = 0;
    foreach (trace[i]) if (!trace[i]) zeros++;
    check_val("midframe_reset_line_idle", zeros, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
